// File: rtl/i2c_calc_pkg.sv
// Shared types and register map for the I2C calculator target.
package i2c_calc_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned PTR_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_PTR,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_MACK
  } state_e;

  localparam logic [PTR_W-1:0] REG_A      = 3'd0;
  localparam logic [PTR_W-1:0] REG_B      = 3'd1;
  localparam logic [PTR_W-1:0] REG_OP     = 3'd2;
  localparam logic [PTR_W-1:0] REG_RES_LO = 3'd3;
  localparam logic [PTR_W-1:0] REG_RES_HI = 3'd4;
  localparam logic [PTR_W-1:0] REG_LAST   = 3'd4;

endpackage

// File: rtl/i2c_calc_target_if.sv
// Pad-level I2C signals between a bus master (or its model) and the target.
interface i2c_calc_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA and emits registered single-cycle SCL edge,
// START and STOP strobes plus the SDA level aligned to those strobes.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_dly_q, sda_dly_q;
  logic       scl_rise_q, scl_rise_d;
  logic       scl_fall_q, scl_fall_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;

  // START/STOP need SCL stable high and win over any coincident SCL edge
  always_comb begin
    start_d    = scl_sync_q[1] & scl_dly_q & sda_dly_q & ~sda_sync_q[1];
    stop_d     = scl_sync_q[1] & scl_dly_q & ~sda_dly_q & sda_sync_q[1];
    scl_rise_d = scl_sync_q[1] & ~scl_dly_q & ~(start_d | stop_d);
    scl_fall_d = ~scl_sync_q[1] & scl_dly_q & ~(start_d | stop_d);
  end

  // Lines reset to the idle-high bus level so reset release is quiet
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_dly_q  <= scl_sync_q[1];
      sda_dly_q  <= sda_sync_q[1];
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_rise = scl_rise_q;
  assign scl_fall = scl_fall_q;
  assign start    = start_q;
  assign stop     = stop_q;
  assign sda      = sda_dly_q;

endmodule

// File: rtl/i2c_calc_target.sv
// I2C target that maps bus transfers onto the calculator's operand,
// operation and result registers.
module i2c_calc_target
  import i2c_calc_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h2A
) (
  input  logic                    clk,
  input  logic                    rst,
  i2c_calc_target_if.slave        bus,
  output logic [BYTE_W-1:0]       first_input_number,
  output logic [BYTE_W-1:0]       second_input_number,
  output logic [1:0]              operation,
  output logic                    operands_valid,
  input  logic [RES_W-1:0]        result
);

  logic scl_rise, scl_fall, start, stop, sda;

  i2c_line_sync u_line_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (bus.scl_in),
    .sda_in   (bus.sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda      (sda)
  );

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [BYTE_W-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]          op_q, op_d;
  logic [RES_W-1:0]    shadow_q, shadow_d;
  logic                rw_q, rw_d;
  logic                wrote_q, wrote_d;
  logic                sda_oe_q, sda_oe_d;
  logic                valid_q, valid_d;
  logic [BYTE_W-1:0]   rx_byte;
  logic [PTR_W-1:0]    ptr_inc;

  function automatic logic [BYTE_W-1:0] rd_sel(input logic [PTR_W-1:0] p,
                                               input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b,
                                               input logic [1:0] op,
                                               input logic [RES_W-1:0] sh);
    case (p)
      REG_A:      rd_sel = a;
      REG_B:      rd_sel = b;
      REG_OP:     rd_sel = {6'd0, op};
      REG_RES_LO: rd_sel = sh[7:0];
      REG_RES_HI: rd_sel = sh[15:8];
      default:    rd_sel = 8'h00;
    endcase
  endfunction

  assign rx_byte = {shift_q[6:0], sda};
  assign ptr_inc = (ptr_q >= REG_LAST) ? REG_A : ptr_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    shadow_d = shadow_q;
    rw_d     = rw_q;
    wrote_d  = wrote_q;
    sda_oe_d = sda_oe_q;
    valid_d  = 1'b0;

    if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      valid_d  = wrote_q;
      wrote_d  = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      wrote_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        // Receive path: shift on SCL rise, keep SDA released on SCL fall
        ADDR, WR_PTR, WR_DATA: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == ADDR) begin
                rw_d    = rx_byte[0];
                state_d = (rx_byte[7:1] == I2C_ADDR) ? ADDR_ACK : IDLE;
              end else if (state_q == WR_PTR) begin
                ptr_d   = rx_byte[2:0];
                state_d = WR_ACK;
              end else begin
                case (ptr_q)
                  REG_A:   a_d  = rx_byte;
                  REG_B:   b_d  = rx_byte;
                  REG_OP:  op_d = rx_byte[1:0];
                  default: ;
                endcase
                wrote_d = 1'b1;
                ptr_d   = ptr_inc;
                state_d = WR_ACK;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b1;
            if (rw_q) shadow_d = result;
          end
          if (scl_rise) begin
            cnt_d   = '0;
            state_d = rw_q ? RD_DATA : WR_PTR;
            if (rw_q) shift_d = rd_sel(ptr_q, a_q, b_q, op_q, shadow_q);
          end
        end
        WR_ACK: begin
          if (scl_fall) sda_oe_d = 1'b1;
          if (scl_rise) begin
            cnt_d   = '0;
            state_d = WR_DATA;
          end
        end
        // Transmit path: present next bit on SCL fall, hand over after 8 rises
        RD_DATA: begin
          if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
            cnt_d    = cnt_q + 4'd1;
          end
          if (scl_rise && cnt_q == 4'd8) begin
            cnt_d   = '0;
            state_d = RD_MACK;
          end
        end
        RD_MACK: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            if (!sda) begin
              ptr_d   = ptr_inc;
              shift_d = rd_sel(ptr_inc, a_q, b_q, op_q, shadow_q);
              state_d = RD_DATA;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      ptr_q    <= REG_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      shadow_q <= '0;
      rw_q     <= 1'b0;
      wrote_q  <= 1'b0;
      sda_oe_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      shadow_q <= shadow_d;
      rw_q     <= rw_d;
      wrote_q  <= wrote_d;
      sda_oe_q <= sda_oe_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.sda_oe          = sda_oe_q;
  assign first_input_number  = a_q;
  assign second_input_number = b_q;
  assign operation           = op_q;
  assign operands_valid      = valid_q;

endmodule

// File: tb/tb_i2c_calc_target.sv
// Bench for i2c_calc_target: bus-level master, register-file reference
// model and a scoreboard fed by the master, drained by a monitor.
module tb_i2c_calc_target;

  localparam int unsigned Q = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_o, b_o;
  logic [1:0]  op_o;
  logic        valid_o;
  logic [15:0] result;

  i2c_calc_target_if bus ();

  i2c_calc_target #(.I2C_ADDR(7'h2A)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus.slave),
    .first_input_number  (a_o),
    .second_input_number (b_o),
    .operation           (op_o),
    .operands_valid      (valid_o),
    .result              (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  typedef logic [7:0] bytes_t[$];

  exp_t        exp_q[$];
  logic [7:0]  obs_q[$];
  logic [17:0] pulse_q[$];
  int          total = 0;
  int          bad   = 0;

  logic [7:0]  mreg [0:2];
  logic [2:0]  mptr;
  logic [15:0] msh;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference register file, written from the map's rules
  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p >= 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [2:0] p);
    case (p)
      3'd0:    return mreg[0];
      3'd1:    return mreg[1];
      3'd2:    return mreg[2];
      3'd3:    return msh[7:0];
      3'd4:    return msh[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic mdl_write(input logic [7:0] v);
    if (mptr <= 3'd2) mreg[mptr] = (mptr == 3'd2) ? {6'd0, v[1:0]} : v;
    mptr = next_ptr(mptr);
  endtask

  task automatic mdl_reset();
    mreg[0] = 8'h00; mreg[1] = 8'h00; mreg[2] = 8'h00;
    mptr = 3'd0; msh = 16'h0000;
  endtask

  task automatic push_exp(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // Bus master primitives; inputs change only on the falling clock edge
  task automatic i2c_start();
    bus.sda_in = 1'b1; wait_clk(Q);
    bus.scl_in = 1'b1; wait_clk(Q);
    bus.sda_in = 1'b0; wait_clk(Q);
    bus.scl_in = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    bus.sda_in = 1'b0; wait_clk(Q);
    bus.scl_in = 1'b1; wait_clk(Q);
    bus.sda_in = 1'b1; wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, input string tag, input logic exp_ack);
    logic ack;
    push_exp(tag, {7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) begin
      bus.sda_in = b[i]; wait_clk(Q);
      bus.scl_in = 1'b1; wait_clk(2 * Q);
      bus.scl_in = 1'b0; wait_clk(Q);
    end
    bus.sda_in = 1'b1; wait_clk(Q);
    bus.scl_in = 1'b1; wait_clk(Q);
    ack = bus.sda_oe;  wait_clk(Q);
    bus.scl_in = 1'b0; wait_clk(Q);
    obs_q.push_back({7'd0, ack});
  endtask

  task automatic rd_byte(input logic nack, input logic [7:0] exp, input string tag);
    logic [7:0] v;
    push_exp(tag, exp);
    bus.sda_in = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q);
      bus.scl_in = 1'b1; wait_clk(Q);
      v[i] = ~bus.sda_oe; wait_clk(Q);
      bus.scl_in = 1'b0; wait_clk(Q);
    end
    bus.sda_in = nack; wait_clk(Q);
    bus.scl_in = 1'b1; wait_clk(2 * Q);
    bus.scl_in = 1'b0; wait_clk(Q);
    bus.sda_in = 1'b1;
    obs_q.push_back(v);
  endtask

  task automatic txn_write(input logic [2:0] p, input bytes_t d);
    i2c_start();
    wr_byte({7'h2A, 1'b0}, "addr_w_ack", 1'b1);
    wr_byte({5'd0, p}, "ptr_ack", 1'b1);
    mptr = p;
    foreach (d[i]) begin
      wr_byte(d[i], "data_ack", 1'b1);
      mdl_write(d[i]);
    end
    if (d.size() > 0) pulse_q.push_back({mreg[0], mreg[1], mreg[2][1:0]});
    i2c_stop();
  endtask

  task automatic txn_read(input logic set_ptr, input logic [2:0] p, input int n);
    if (set_ptr) begin
      i2c_start();
      wr_byte({7'h2A, 1'b0}, "addr_w_ack", 1'b1);
      wr_byte({5'd0, p}, "ptr_ack", 1'b1);
      mptr = p;
    end
    i2c_start();
    msh = result;
    wr_byte({7'h2A, 1'b1}, "addr_r_ack", 1'b1);
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, mdl_rd(mptr), "rd_byte");
      if (i == 0) result = 16'($urandom);
      if (i != n - 1) mptr = next_ptr(mptr);
    end
    i2c_stop();
  endtask

  // Monitor: pairs observed bus responses and operand pulses with expectations
  initial begin : sb_mon
    exp_t       e;
    logic [7:0] o;
    logic [17:0] pe;
    forever begin
      @(negedge clk);
      if (valid_o) begin
        if (pulse_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pulse: unexpected operands_valid with A=%0h B=%0h op=%0h", a_o, b_o, op_o);
        end else begin
          pe = pulse_q.pop_front();
          check("pulse_regs", {14'd0, a_o, b_o, op_o}, {14'd0, pe});
        end
      end
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_orphan: got 0x%0h expected nothing", o);
        end else begin
          e = exp_q.pop_front();
          check(e.tag, {24'd0, o}, {24'd0, e.v});
        end
      end
    end
  end

  initial begin : stim
    bytes_t     d;
    logic [2:0] p;
    int         k;
    logic       acc;

    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    rst        = 1'b1;
    result     = 16'h0000;
    mdl_reset();
    wait_clk(4);
    check("rst_a", {24'd0, a_o}, 32'h0);
    check("rst_b", {24'd0, b_o}, 32'h0);
    check("rst_op", {30'd0, op_o}, 32'h0);
    check("rst_valid", {31'd0, valid_o}, 32'h0);
    check("rst_sda_oe", {31'd0, bus.sda_oe}, 32'h0);
    rst = 1'b0;
    wait_clk(Q);

    // Basic operand write
    d = {}; d.push_back(8'h12); d.push_back(8'h34); d.push_back(8'h01);
    txn_write(3'd0, d);
    check("wr_regs", {14'd0, a_o, b_o, op_o}, {14'd0, 8'h12, 8'h34, 2'b01});

    // Foreign address is not acknowledged and changes nothing
    i2c_start();
    wr_byte({7'h2B, 1'b0}, "addr_foreign_nack", 1'b0);
    i2c_stop();
    check("foreign_regs", {14'd0, a_o, b_o, op_o}, {14'd0, 8'h12, 8'h34, 2'b01});

    // Result readback from the shadow, result changed mid-read
    result = 16'hBEEF;
    txn_read(1'b1, 3'd3, 2);

    // Pointer wrap 4 -> 0
    d = {}; d.push_back(8'h55); d.push_back(8'h66);
    txn_write(3'd4, d);
    check("wrap_a", {24'd0, a_o}, 32'h66);
    txn_read(1'b1, 3'd0, 1);

    // STOP in the middle of a read byte while the target holds SDA low
    d = {}; d.push_back(8'h00);
    txn_write(3'd0, d);
    i2c_start();
    wr_byte({7'h2A, 1'b0}, "addr_w_ack", 1'b1);
    wr_byte(8'h00, "ptr_ack", 1'b1);
    mptr = 3'd0;
    i2c_start();
    msh = result;
    wr_byte({7'h2A, 1'b1}, "addr_r_ack", 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_clk(Q);
      bus.scl_in = 1'b1; wait_clk(2 * Q);
      bus.scl_in = 1'b0; wait_clk(Q);
    end
    check("rd_drive_low", {31'd0, bus.sda_oe}, 32'h1);
    bus.sda_in = 1'b0; wait_clk(Q);
    bus.scl_in = 1'b1; wait_clk(Q);
    bus.sda_in = 1'b1;
    k = 99;
    for (int i = 1; i <= 10; i++) begin
      wait_clk(1);
      if (k == 99 && bus.sda_oe == 1'b0) k = i;
    end
    check("stop_release_clks_le4", {31'd0, (k <= 4)}, 32'h1);
    acc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.scl_in = 1'b0; wait_clk(Q);
      acc |= bus.sda_oe;
      bus.scl_in = 1'b1; wait_clk(Q);
      acc |= bus.sda_oe;
    end
    check("idle_after_stop", {31'd0, acc}, 32'h0);

    // Randomised traffic against the reference model
    for (int t = 0; t < 12; t++) begin
      p = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 0) begin
        d = {};
        for (int j = 0; j < int'($urandom_range(0, 3)); j++) d.push_back(8'($urandom));
        txn_write(p, d);
      end else begin
        result = 16'($urandom);
        txn_read(1'($urandom_range(0, 1)), p, int'($urandom_range(1, 3)));
      end
    end

    // Reset during the 4th data bit of a write
    d = {}; d.push_back(8'hA5); d.push_back(8'h5A); d.push_back(8'h03);
    txn_write(3'd0, d);
    i2c_start();
    wr_byte({7'h2A, 1'b0}, "addr_w_ack", 1'b1);
    wr_byte(8'h00, "ptr_ack", 1'b1);
    for (int i = 7; i >= 5; i--) begin
      bus.sda_in = 1'b1; wait_clk(Q);
      bus.scl_in = 1'b1; wait_clk(2 * Q);
      bus.scl_in = 1'b0; wait_clk(Q);
    end
    bus.sda_in = 1'b0; wait_clk(Q);
    bus.scl_in = 1'b1; wait_clk(Q / 2);
    rst = 1'b1;
    wait_clk(2);
    check("midrst_regs", {14'd0, a_o, b_o, op_o}, 32'h0);
    check("midrst_sda_oe", {31'd0, bus.sda_oe}, 32'h0);
    check("midrst_valid", {31'd0, valid_o}, 32'h0);
    rst = 1'b0;
    mdl_reset();
    wait_clk(Q);
    bus.scl_in = 1'b0; wait_clk(Q);
    i2c_stop();
    d = {}; d.push_back(8'($urandom)); d.push_back(8'($urandom)); d.push_back(8'($urandom));
    txn_write(3'd0, d);
    result = 16'($urandom);
    txn_read(1'b1, 3'd0, 3);

    wait_clk(4 * Q);
    check("sb_exp_drained", exp_q.size(), 32'h0);
    check("sb_pulse_drained", pulse_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_calc_target.md
# i2c_calc_target

I2C target (slave) front-end for the calculator. It oversamples the pad-level SCL/SDA on the system clock, decodes START/STOP/address/data, and maps bus transfers onto a small register file. That register file drives the calculator's `first_input_number`, `second_input_number` and `operation` inputs, and returns the calculator's `result` on reads. It sits directly upstream of the calculator instance inside `tt_um_bsrk_i2c_calc`.

## Interface
- `I2C_ADDR`, default 7'h2A: 7-bit target address.
- `clk` in 1: system clock. Must be ≥16× SCL frequency.
- `rst` in 1: synchronous, active-high reset.
- `scl_in` in 1: raw SCL pad input, asynchronous.
- `sda_in` in 1: raw SDA pad input, asynchronous.
- `sda_oe` out 1: 1 pulls SDA low. Pad output data is tied 0.
- `first_input_number` out 8: register 0x00.
- `second_input_number` out 8: register 0x01.
- `operation` out 2: register 0x02, bits [1:0].
- `operands_valid` out 1: one-cycle pulse on STOP ending a write that stored ≥1 data byte.
- `result` in 16: calculator result, read via registers 0x03 (low byte) and 0x04 (high byte).

## Operation
- Input conditioning:
  - 2-flop synchronizer per line, plus a delayed copy for edge detection.
  - Events are SCL rise, SCL fall, START and STOP.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_MACK.
- IDLE → ADDR on START.
- ADDR:
  - Shift 8 bits MSB-first on SCL rise.
  - If [7:1]==I2C_ADDR, go to ADDR_ACK.
  - Otherwise go to IDLE and ignore traffic until the next START.
- ADDR_ACK: drive ACK (sda_oe=1) for one SCL low+high period.
  - R/W=0: go to WR_PTR.
  - R/W=1: go to RD_DATA. Snapshot `result` into a 16-bit shadow at this ACK.
- WR_PTR: first byte loads the pointer (bits [2:0]). ACK, then WR_DATA.
- WR_DATA: each byte is written to reg[ptr], then ACK, then ptr advances.
  - Writes to 0x03/0x04 or ptr>4 are ACKed and discarded.
  - `operation` takes data[1:0].
- RD_DATA: shift out reg[ptr] MSB-first.
  - sda_oe = ~bit, updated on SCL fall.
  - 0x03/0x04 read from the shadow. ptr>4 reads 0x00.
- RD_MACK: sample master ACK on SCL rise.
  - ACK (0): ptr advances, return to RD_DATA.
  - NACK: release SDA and wait in IDLE for STOP/START.
- Pointer wrap: 4 → 0. The pointer persists across transactions and resets to 0.
- Repeated START in any state returns to ADDR. No `operands_valid` pulse.
- STOP in any state goes to IDLE with sda_oe=0 the next cycle.
- Reset, including mid-transfer:
  - IDLE, all registers 0, ptr 0, shadow 0.
  - sda_oe=0, operands_valid=0.

## Timing
- Event detect latency: 3 clk from pad edge to internal event.
- sda_oe changes exactly 1 clk after a detected SCL fall. It is never changed while SCL is high, except released on STOP/reset.
- Register outputs update 1 clk after the SCL rise that captures bit 0 of the data byte.
- `operands_valid` asserts 1 clk after STOP detect, for exactly 1 clk.
- Simultaneous START/STOP and an SCL edge in the same cycle: START/STOP takes priority.

## Structure
- Package `i2c_calc_pkg` holds:
  - FSM state enum.
  - Register address constants: REG_A=0, REG_B=1, REG_OP=2, REG_RES_LO=3, REG_RES_HI=4, REG_LAST=4.
- Sub-module `i2c_line_sync`: synchronizer plus edge/START/STOP detector, emitting single-cycle event strobes. Instantiated once.

## Test plan
- Write 0x2A+W, ptr 0x00, data 0x12, 0x34, 0x01, STOP:
  - Outputs A=0x12, B=0x34, op=2'b01.
  - One `operands_valid` pulse.
  - Three data ACKs plus address ACK.
- Address 0x2B+W: no ACK (sda_oe stays 0), registers unchanged, no pulse.
- result=16'hBEEF. Write ptr 0x03, repeated START, 0x2A+R, read 2 bytes (ACK then NACK):
  - Bytes 0xEF, 0xBE.
  - Changing `result` mid-read has no effect.
- Pointer wrap: write ptr 0x04, then data 0x55, 0x66:
  - 0x55 is discarded.
  - 0x66 lands in A.
  - Next read from ptr 0 returns 0x66.
- Assert `rst` during the 4th data bit of a write: sda_oe=0, IDLE, all outputs 0. A subsequent full write succeeds.
- STOP injected mid-byte in RD_DATA: SDA released within 1 clk of STOP detect, FSM IDLE, no pulse.
